// File: rtl/bitty_fetch_ctrl.sv
// bitty_fetch_ctrl: runs a short program on the bitty core.
// The controller fetches each instruction from a synchronous-read instruction
// memory and holds it on core_instr with core_run high until the core reports
// done. A watchdog bounds each instruction, and abort cancels the run.
// All outputs are registered.
module bitty_fetch_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int MIN_EXEC = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   prog_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              core_run,
  output logic [15:0]       core_instr,
  input  logic              core_done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              finished,
  output logic              error
);

  // The counter must be able to hold TIMEOUT itself, because it saturates there.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_WAIT_MEM = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_NEXT     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W:0]   len_q;
  logic [CNT_W-1:0]  exec_cnt;
  logic [ADDR_W:0]   pc_inc;
  logic              exec_complete;
  logic              exec_timeout;

  // Decode EXEC exit conditions and the widened next pc.
  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    pc_inc        = {1'b0, pc} + 1'b1;
    exec_complete = 1'b0;
    exec_timeout  = 1'b0;
    if (state == S_EXEC) begin
      exec_complete = core_done && (exec_cnt >= CNT_W'(MIN_EXEC - 1));
      exec_timeout  = (exec_cnt == CNT_W'(TIMEOUT - 1));
    end
  end

  // Sequencer state, program counter and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      len_q      <= '0;
      exec_cnt   <= '0;
      core_run   <= 1'b0;
      core_instr <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      error      <= 1'b0;
    end else begin
      finished <= 1'b0;
      if (abort && state != S_IDLE) begin
        // Abort beats every other transition; pc and error are kept for inspection.
        state     <= S_IDLE;
        core_run  <= 1'b0;
        mem_rd_en <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              len_q    <= prog_len;
              pc       <= '0;
              mem_addr <= '0;
              error    <= 1'b0;
              busy     <= 1'b1;
              if (prog_len == '0) begin
                state <= S_DONE;
              end else begin
                state     <= S_FETCH;
                mem_rd_en <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            mem_rd_en <= 1'b0;
            state     <= S_WAIT_MEM;
          end
          S_WAIT_MEM: begin
            core_instr <= mem_rdata;
            exec_cnt   <= '0;
            core_run   <= 1'b1;
            state      <= S_EXEC;
          end
          S_EXEC: begin
            if (exec_cnt != CNT_W'(TIMEOUT)) begin
              exec_cnt <= exec_cnt + 1'b1;
            end
            // Completion is checked first so it wins over a same-cycle timeout.
            if (exec_complete) begin
              core_run <= 1'b0;
              state    <= S_NEXT;
            end else if (exec_timeout) begin
              core_run <= 1'b0;
              error    <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end
          end
          S_NEXT: begin
            // Wide compare lets a full 2^ADDR_W program end without pc wrapping.
            if (pc_inc == len_q) begin
              state <= S_DONE;
            end else begin
              pc        <= pc_inc[ADDR_W-1:0];
              mem_addr  <= pc_inc[ADDR_W-1:0];
              mem_rd_en <= 1'b1;
              state     <= S_FETCH;
            end
          end
          S_DONE: begin
            finished <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
          default: begin
            state     <= S_IDLE;
            core_run  <= 1'b0;
            mem_rd_en <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bitty_fetch_ctrl.sv
// Testbench for bitty_fetch_ctrl: an instruction memory model and a bitty core
// model drive the DUT. Stimulus pushes the expected run segments into a
// scoreboard queue, and a monitor pops and compares them whenever core_run rises.
module tb_bitty_fetch_ctrl;

  localparam int ADDR_W   = 8;
  localparam int MIN_EXEC = 3;
  localparam int TIMEOUT  = 16;
  localparam int DEPTH    = 1 << ADDR_W;

  localparam int M_NORMAL = 0;
  localparam int M_STICKY = 1;
  localparam int M_STUCK  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   prog_len = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata = '0;
  logic              core_run;
  logic [15:0]       core_instr;
  logic              core_done = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              finished;
  logic              error;

  bitty_fetch_ctrl #(.ADDR_W(ADDR_W), .MIN_EXEC(MIN_EXEC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .prog_len(prog_len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .core_run(core_run), .core_instr(core_instr), .core_done(core_done),
    .pc(pc), .busy(busy), .finished(finished), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          addr;
    int          len;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem [DEPTH];
  int          total = 0;
  int          bad = 0;
  int          fin_cnt = 0;
  int          seg_cnt = 0;
  int          rd_cnt = 0;
  bit          skip_len = 1'b0;
  int          core_mode = M_NORMAL;
  int          core_lat = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read instruction memory.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Core model: done once it has been running core_lat cycles, or forced high/low.
  int run_cnt = 0;
  always @(negedge clk) begin
    if (core_run) run_cnt++;
    else run_cnt = 0;
    case (core_mode)
      M_STICKY: core_done = 1'b1;
      M_STUCK:  core_done = 1'b0;
      default:  core_done = (run_cnt >= core_lat);
    endcase
  end

  // Monitor: one scoreboard entry per run segment.
  exp_t cur = '{instr: '0, addr: 0, len: 0};
  bit   prev_run = 1'b0;
  int   seg_len = 0;
  always @(negedge clk) begin
    if (finished) fin_cnt++;
    if (mem_rd_en) rd_cnt++;
    if (core_run && !prev_run) begin
      seg_cnt++;
      seg_len = 1;
      if (q.size() == 0) begin
        check("unexpected_run", 32'd1, 32'd0);
      end else begin
        cur = q.pop_front();
        check("instr", 32'(core_instr), 32'(cur.instr));
        check("run_pc", 32'(pc), 32'(cur.addr));
        check("run_addr", 32'(mem_addr), 32'(cur.addr));
      end
    end else if (core_run) begin
      seg_len++;
      if (core_instr !== cur.instr) check("instr_hold", 32'(core_instr), 32'(cur.instr));
    end else if (prev_run && !skip_len) begin
      check("run_len", 32'(seg_len), 32'(cur.len));
    end
    prev_run = core_run;
  end

  function automatic int exp_run_len(input int mode, input int lat);
    if (mode == M_STICKY) return MIN_EXEC;
    if (mode == M_STUCK) return TIMEOUT;
    return (lat > MIN_EXEC) ? lat : MIN_EXEC;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic issue_start(input int len);
    start    = 1'b1;
    prog_len = (ADDR_W + 1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Full program with scoreboard expectations; optionally pokes start mid-run.
  task automatic run_prog(input int len, input int mode, input int lat, input bit poke);
    int f0, n;
    bit stuck;
    stuck = (mode == M_STUCK);
    core_mode = mode;
    core_lat  = lat;
    if (stuck) q.push_back('{instr: mem[0], addr: 0, len: TIMEOUT});
    else for (int i = 0; i < len; i++) q.push_back('{instr: mem[i], addr: i, len: exp_run_len(mode, lat)});
    f0 = fin_cnt;
    issue_start(len);
    @(negedge clk);
    check("err_clr_on_start", 32'(error), 32'd0);
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
      if (poke && n == 5) begin start = 1'b1; prog_len = 9'd7; end
      if (poke && n == 6) start = 1'b0;
    end
    start = 1'b0;
    if (busy) check("prog_timeout", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("fin_cnt", 32'(fin_cnt - f0), stuck ? 32'd0 : 32'd1);
    check("error", 32'(error), stuck ? 32'd1 : 32'd0);
    check("end_pc", 32'(pc), stuck ? 32'd0 : 32'(len - 1));
    check("q_empty", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int f0, s0, n;
    fill_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_run", 32'(core_run), 32'd0);
    check("rst_rd", 32'(mem_rd_en), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(core_instr), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed: 3-instruction program with latency checks.
    mem[0] = 16'hA1A1; mem[1] = 16'hB2B2; mem[2] = 16'hC3C3;
    core_mode = M_NORMAL; core_lat = 3;
    for (int i = 0; i < 3; i++) q.push_back('{instr: mem[i], addr: i, len: 3});
    f0 = fin_cnt;
    issue_start(3);
    @(negedge clk);
    check("t1_rd_en", 32'(mem_rd_en), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'd0);
    check("t1_run", 32'(core_run), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t2_rd_en", 32'(mem_rd_en), 32'd0);
    check("t2_run", 32'(core_run), 32'd0);
    @(negedge clk);
    check("t3_run", 32'(core_run), 32'd1);
    check("t3_instr", 32'(core_instr), 32'hA1A1);
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    check("d1_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("d1_fin", 32'(fin_cnt - f0), 32'd1);
    check("d1_pc", 32'(pc), 32'd2);
    check("d1_err", 32'(error), 32'd0);
    check("d1_q", 32'(q.size()), 32'd0);

    // prog_len == 0: no fetch, no run, finished two cycles after start.
    s0 = seg_cnt; n = rd_cnt;
    issue_start(0);
    @(negedge clk);
    check("z_fin_early", 32'(finished), 32'd0);
    check("z_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("z_fin", 32'(finished), 32'd1);
    check("z_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("z_no_rd", 32'(rd_cnt - n), 32'd0);
    check("z_no_run", 32'(seg_cnt - s0), 32'd0);

    // Watchdog, then a normal program that must clear error.
    fill_mem();
    run_prog(2, M_STUCK, 0, 1'b0);
    check("wd_busy", 32'(busy), 32'd0);
    run_prog(1, M_NORMAL, 2, 1'b0);

    // Sticky done still gives MIN_EXEC run cycles per instruction.
    fill_mem();
    run_prog(4, M_STICKY, 0, 1'b0);

    // Randomized programs; odd ones also pulse start while busy.
    for (int k = 0; k < 6; k++) begin
      fill_mem();
      run_prog(int'($urandom_range(1, 6)), int'($urandom_range(0, 1)),
               int'($urandom_range(1, 7)), k[0]);
    end

    // Full-depth program: pc must reach the last address with no wrap.
    fill_mem();
    run_prog(DEPTH, M_STICKY, 0, 1'b0);

    // Abort during EXEC of instruction 1.
    fill_mem();
    core_mode = M_NORMAL; core_lat = 6;
    for (int i = 0; i < 3; i++) q.push_back('{instr: mem[i], addr: i, len: 6});
    f0 = fin_cnt; s0 = seg_cnt;
    issue_start(3);
    n = 0;
    while (seg_cnt < s0 + 2 && n < 200) begin @(posedge clk); #1; n++; end
    check("ab_reached", 32'(seg_cnt - s0), 32'd2);
    abort = 1'b1;
    skip_len = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("ab_run", 32'(core_run), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_pc", 32'(pc), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    skip_len = 1'b0;
    q.delete();
    check("ab_fin", 32'(fin_cnt - f0), 32'd0);
    check("ab_still_idle", 32'(busy), 32'd0);

    // Start and abort together in IDLE: start ignored.
    start = 1'b1; abort = 1'b1; prog_len = 9'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_rd", 32'(mem_rd_en), 32'd0);
    @(posedge clk); #1;

    // Reset during WAIT_MEM.
    issue_start(3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_run", 32'(core_run), 32'd0);
    check("mr_rd", 32'(mem_rd_en), 32'd0);
    check("mr_addr", 32'(mem_addr), 32'd0);
    check("mr_pc", 32'(pc), 32'd0);
    check("mr_instr", 32'(core_instr), 32'd0);
    check("mr_fin", 32'(finished), 32'd0);
    check("mr_err", 32'(error), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("mr_no_run", 32'(core_run), 32'd0);
    q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
